// File: rtl/bru.sv
// Branch resolution unit: one-cycle registered ALU/target result plus a
// conditional-branch taken flag. Optional feature macro: BRU_JALR_ALIGN_EN
// (clears bit 0 of the JALR target).
module bru (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [4:0]  i_instr,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_fwd_en,
  output logic        o_valid,
  output logic [31:0] o_data_buff,
  output logic [4:0]  o_rd_addr,
  output logic        o_fwd_en,
  output logic        o_taken
);

  localparam int STAGES = 1;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLT  = 5'd2,  OP_SLTU = 5'd3,
    OP_XOR  = 5'd4,  OP_OR   = 5'd5,  OP_AND  = 5'd6,  OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,  OP_SRA  = 5'd9,
    OP_BEQ  = 5'd10, OP_BNE  = 5'd11, OP_BLT  = 5'd12, OP_BGE  = 5'd13,
    OP_BLTU = 5'd14, OP_BGEU = 5'd15,
    OP_JAL  = 5'd16, OP_JALR = 5'd17,
    OP_LB   = 5'd18, OP_LH   = 5'd19, OP_LW   = 5'd20, OP_LBU  = 5'd21,
    OP_LHU  = 5'd22, OP_SB   = 5'd23, OP_SH   = 5'd24, OP_SW   = 5'd25
  } operator_e;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fwd;
    logic        taken;
  } rsp_t;

  logic [STAGES:0] vld_pipe;
  operator_e       op;
  rsp_t            rsp_d, rsp_q;
  logic [4:0]      shamt;
  logic            eq, lt_s, lt_u;

  assign op          = operator_e'(i_instr);
  assign shamt       = i_operand_b[4:0];
  assign eq          = (i_rs1_data == i_rs2_data);
  assign lt_s        = ($signed(i_rs1_data) < $signed(i_rs2_data));
  assign lt_u        = (i_rs1_data < i_rs2_data);
  assign vld_pipe[0] = i_valid;

  // Next-cycle response; an invalid op collapses to all zeros.
  always_comb begin
    rsp_d = '0;
    if (i_valid) begin
      rsp_d.rd  = i_rd_addr;
      rsp_d.fwd = i_fwd_en;
      case (op)
        OP_SUB:  rsp_d.data = i_operand_a - i_operand_b;
        OP_SLT:  rsp_d.data = {31'd0, $signed(i_operand_a) < $signed(i_operand_b)};
        OP_SLTU: rsp_d.data = {31'd0, i_operand_a < i_operand_b};
        OP_XOR:  rsp_d.data = i_operand_a ^ i_operand_b;
        OP_OR:   rsp_d.data = i_operand_a | i_operand_b;
        OP_AND:  rsp_d.data = i_operand_a & i_operand_b;
        OP_SLL:  rsp_d.data = i_operand_a << shamt;
        OP_SRL:  rsp_d.data = i_operand_a >> shamt;
        OP_SRA:  rsp_d.data = $unsigned($signed(i_operand_a) >>> shamt);
        // ADD, branch/jump targets, load/store addresses and unused codes
        default: rsp_d.data = i_operand_a + i_operand_b;
      endcase
`ifdef BRU_JALR_ALIGN_EN
      if (op == OP_JALR) rsp_d.data[0] = 1'b0;
`endif
      // Only conditional branches resolve taken; jumps report 0.
      case (op)
        OP_BEQ:  rsp_d.taken = eq;
        OP_BNE:  rsp_d.taken = ~eq;
        OP_BLT:  rsp_d.taken = lt_s;
        OP_BGE:  rsp_d.taken = ~lt_s;
        OP_BLTU: rsp_d.taken = lt_u;
        OP_BGEU: rsp_d.taken = ~lt_u;
        default: rsp_d.taken = 1'b0;
      endcase
    end
  end

  // Output register stage; reset drops whatever is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe[STAGES:1] <= '0;
      rsp_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      rsp_q              <= rsp_d;
    end
  end

  assign o_valid     = vld_pipe[STAGES];
  assign o_data_buff = rsp_q.data;
  assign o_rd_addr   = rsp_q.rd;
  assign o_fwd_en    = rsp_q.fwd;
  assign o_taken     = rsp_q.taken;

endmodule

// File: tb/tb_bru.sv
// Bench for bru: table of directed vectors plus reset/back-to-back sequences,
// expectations queued at drive time and compared one cycle later.
module tb_bru;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_fwd_en;
  logic [4:0]  i_instr, i_rd_addr;
  logic [31:0] i_operand_a, i_operand_b, i_rs1_data, i_rs2_data;
  logic        o_valid, o_fwd_en, o_taken;
  logic [31:0] o_data_buff;
  logic [4:0]  o_rd_addr;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  bru dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr),
    .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_rd_addr(i_rd_addr), .i_fwd_en(i_fwd_en),
    .o_valid(o_valid), .o_data_buff(o_data_buff), .o_rd_addr(o_rd_addr),
    .o_fwd_en(o_fwd_en), .o_taken(o_taken)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  instr;
    logic [31:0] a, b, rs1, rs2;
    logic [4:0]  rd;
    logic        fwd;
    logic [31:0] e_data;
    logic        e_taken;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fwd;
    logic        taken;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at negedge, queue its expectation, then
  // compare just after the capturing edge.
  task automatic step(input string name, input logic rst, input logic valid,
                      input logic [4:0] instr, input logic [31:0] a, b, rs1, rs2,
                      input logic [4:0] rd, input logic fwd,
                      input logic [31:0] e_data, input logic e_taken);
    exp_t e;
    @(negedge i_clk);
    i_rst = rst; i_valid = valid; i_instr = instr;
    i_operand_a = a; i_operand_b = b; i_rs1_data = rs1; i_rs2_data = rs2;
    i_rd_addr = rd; i_fwd_en = fwd;
    e.name  = name;
    e.valid = valid && !rst;
    e.data  = e.valid ? e_data : 32'd0;
    e.rd    = e.valid ? rd : 5'd0;
    e.fwd   = e.valid ? fwd : 1'b0;
    e.taken = e.valid ? e_taken : 1'b0;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".valid"}, {31'd0, o_valid}, {31'd0, e.valid});
      chk({e.name, ".data"},  o_data_buff, e.data);
      chk({e.name, ".rd"},    {27'd0, o_rd_addr}, {27'd0, e.rd});
      chk({e.name, ".fwd"},   {31'd0, o_fwd_en}, {31'd0, e.fwd});
      chk({e.name, ".taken"}, {31'd0, o_taken}, {31'd0, e.taken});
    end
  endtask

  function automatic vec_t mk(string n, logic [4:0] op, logic [31:0] a, b, rs1, rs2,
                              logic [31:0] ed, logic et);
    vec_t v;
    v.name = n; v.valid = 1'b1; v.instr = op; v.a = a; v.b = b;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = 5'd3; v.fwd = 1'b0;
    v.e_data = ed; v.e_taken = et;
    return v;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    vec_t v;
    i_rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_operand_a = '0; i_operand_b = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_rd_addr = '0; i_fwd_en = 1'b0;

    // Reset held two cycles with a valid op on the inputs: discarded.
    step("rst0", 1'b1, 1'b1, 5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd9, 1'b1, 32'd0, 1'b0);
    step("rst1", 1'b1, 1'b1, 5'd10, 32'd1, 32'd2, 32'd4, 32'd4, 5'd9, 1'b1, 32'd0, 1'b0);
    // Invalid ops with random operands: all outputs zero.
    for (int i = 0; i < 4; i++)
      step("inval", 1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom, $urandom,
           $urandom, $urandom, 5'($urandom), 1'b1, 32'd0, 1'b0);

    vecs.push_back(mk("blt",   5'd12, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1, 32'h120, 1'b1));
    vecs.push_back(mk("bltu",  5'd14, 32'h100, 32'h20, 32'hFFFFFFFF, 32'h1, 32'h120, 1'b0));
    vecs.push_back(mk("bgeu",  5'd15, 32'h1000, 32'hFFFFFFFC, 32'h5, 32'h5, 32'hFFC, 1'b1));
    vecs.push_back(mk("bne",   5'd11, 32'h7, 32'h9, 32'h5, 32'h5, 32'h10, 1'b0));
    vecs.push_back(mk("bge",   5'd13, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1));
    vecs.push_back(mk("beq_n", 5'd10, 32'h4, 32'h4, 32'h1, 32'h2, 32'h8, 1'b0));
    vecs.push_back(mk("sra",   5'd9, 32'h80000000, 32'h24, 32'h0, 32'h1, 32'hF8000000, 1'b0));
    vecs.push_back(mk("sub",   5'd1, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("slt",   5'd2, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk("sltu",  5'd3, 32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk("sll",   5'd7, 32'h1, 32'h3F, 32'h0, 32'h0, 32'h80000000, 1'b0));
    vecs.push_back(mk("srl",   5'd8, 32'h80000000, 32'h1F, 32'h0, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk("xor",   5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 32'h0FF00FF0, 1'b0));
    vecs.push_back(mk("or",    5'd5, 32'hF0F0F0F0, 32'h0F000000, 32'h0, 32'h0, 32'hFFF0F0F0, 1'b0));
    vecs.push_back(mk("and",   5'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 32'hF000F000, 1'b0));
    vecs.push_back(mk("add_w", 5'd0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk("jal",   5'd16, 32'h2000, 32'h10, 32'h3, 32'h3, 32'h2010, 1'b0));
    vecs.push_back(mk("sw",    5'd25, 32'h300, 32'hFFFFFFFC, 32'h3, 32'h3, 32'h2FC, 1'b0));
    vecs.push_back(mk("op31",  5'd31, 32'd10, 32'd20, 32'h3, 32'h3, 32'd30, 1'b0));
`ifdef BRU_JALR_ALIGN_EN
    vecs.push_back(mk("jalr",  5'd17, 32'h1001, 32'h2, 32'h0, 32'h0, 32'h1002, 1'b0));
`else
    vecs.push_back(mk("jalr",  5'd17, 32'h1001, 32'h2, 32'h0, 32'h0, 32'h1003, 1'b0));
`endif
    v = mk("pass", 5'd0, 32'h3, 32'h4, 32'h6, 32'h6, 32'h7, 1'b0);
    v.rd = 5'd17; v.fwd = 1'b1;
    vecs.push_back(v);
    v.name = "pass_clr"; v.valid = 1'b0;
    vecs.push_back(v);

    foreach (vecs[i])
      step(vecs[i].name, 1'b0, vecs[i].valid, vecs[i].instr, vecs[i].a, vecs[i].b,
           vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].fwd, vecs[i].e_data, vecs[i].e_taken);

    // Back-to-back BEQ (taken) / LW alternating every cycle.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 2 == 0)
        step("b2b_beq", 1'b0, 1'b1, 5'd10, ra, rb, 32'hABCD, 32'hABCD, 5'(i), 1'b0, ra + rb, 1'b1);
      else
        step("b2b_lw", 1'b0, 1'b1, 5'd20, ra, rb, 32'hABCD, 32'hABCD, 5'(i), 1'b1, ra + rb, 1'b0);
    end

    // Valid op in flight, then reset: dropped; first post-reset op appears next cycle.
    step("pre_rst", 1'b0, 1'b1, 5'd10, 32'h1, 32'h1, 32'h8, 32'h8, 5'd4, 1'b1, 32'h2, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 5'd10, 32'h1, 32'h1, 32'h8, 32'h8, 5'd4, 1'b1, 32'h0, 1'b0);
    step("post_rst", 1'b0, 1'b1, 5'd12, 32'h5, 32'h6, 32'h80000000, 32'h0, 5'd21, 1'b1, 32'hB, 1'b1);
    step("idle", 1'b0, 1'b0, 5'd0, 32'h5, 32'h6, 32'h0, 32'h0, 5'd21, 1'b1, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
